// File: rtl/lsu_pkg.sv
// Shared types and decode helpers for the load/store unit controller.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} lsu_state_e;

  typedef enum logic [1:0] {
    CAUSE_MISALIGN = 2'd0,
    CAUSE_BUS      = 2'd1,
    CAUSE_TIMEOUT  = 2'd2,
    CAUSE_ILLEGAL  = 2'd3
  } lsu_cause_e;

  function automatic logic is_illegal(input logic we, input logic [2:0] f3);
    if (we) return (f3 >= 3'b011);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

  // funct3[1:0] encodes access size for both loads and stores.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b01:   return off[0];
      2'b10:   return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Byte-aligns a returned memory word and sign/zero-extends it per load funct3.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  input  logic [31:0] word,
  output logic [31:0] data
);

  logic [31:0] shifted;

  assign shifted = word >> {off, 3'b000};

  always_comb begin
    data = '0;
    case (funct3)
      F3_LB:   data = {{24{shifted[7]}}, shifted[7:0]};
      F3_LH:   data = {{16{shifted[15]}}, shifted[15:0]};
      F3_LW:   data = shifted;
      F3_LBU:  data = {24'h0, shifted[7:0]};
      F3_LHU:  data = {16'h0, shifted[15:0]};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: request decode, bus handshakes, timeout and late-response drain.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [1:0]  resp_cause,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_we,
  output logic [31:0] mem_req_addr,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_wstrb,
  input  logic        mem_rsp_valid,
  output logic        mem_rsp_ready,
  input  logic [31:0] mem_rsp_rdata,
  input  logic        mem_rsp_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  lsu_state_e       state;
  logic             drain;
  logic [CNT_W-1:0] cnt;
  logic             cap_we;
  logic [2:0]       cap_f3;
  logic [1:0]       cap_off;
  logic [31:0]      load_data;
  logic             req_fire;
  logic             rsp_fire;
  logic             timeout_hit;

  function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] wd);
    case (f3)
      F3_SB:   return {4{wd[7:0]}};
      F3_SH:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [3:0] store_wstrb(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_SB:   return 4'b0001 << off;
      F3_SH:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  lsu_load_align u_align (
    .off    (cap_off),
    .funct3 (cap_f3),
    .word   (mem_rsp_rdata),
    .data   (load_data)
  );

  assign req_ready     = (state == IDLE) && !drain;
  assign mem_rsp_ready = (state == WAIT) || drain;
  assign req_fire      = req_valid && req_ready;
  assign rsp_fire      = mem_rsp_valid && mem_rsp_ready;
  assign timeout_hit   = (cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      drain         <= 1'b0;
      cnt           <= '0;
      cap_we        <= 1'b0;
      cap_f3        <= '0;
      cap_off       <= '0;
      mem_req_valid <= 1'b0;
      mem_req_we    <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wdata <= '0;
      mem_req_wstrb <= '0;
      resp_valid    <= 1'b0;
      resp_rdata    <= '0;
      resp_err      <= 1'b0;
      resp_cause    <= '0;
    end else begin
      // A drained late response is simply discarded.
      if (drain && rsp_fire) drain <= 1'b0;

      case (state)
        IDLE: begin
          if (req_fire) begin
            cap_we  <= req_we;
            cap_f3  <= req_funct3;
            cap_off <= req_addr[1:0];
            if (is_illegal(req_we, req_funct3)) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_cause <= CAUSE_ILLEGAL;
              resp_rdata <= '0;
            end else if (is_misaligned(req_funct3, req_addr[1:0])) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_cause <= CAUSE_MISALIGN;
              resp_rdata <= '0;
            end else begin
              state         <= REQ;
              cnt           <= '0;
              mem_req_valid <= 1'b1;
              mem_req_we    <= req_we;
              mem_req_addr  <= {req_addr[31:2], 2'b00};
              mem_req_wdata <= req_we ? store_wdata(req_funct3, req_wdata) : 32'h0;
              mem_req_wstrb <= req_we ? store_wstrb(req_funct3, req_addr[1:0]) : 4'b0000;
            end
          end
        end

        REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= WAIT;
            cnt           <= cnt + 1'b1;
          end else if (timeout_hit) begin
            // Nothing was issued, so no response can be left outstanding.
            mem_req_valid <= 1'b0;
            state         <= RESP;
            resp_valid    <= 1'b1;
            resp_err      <= 1'b1;
            resp_cause    <= CAUSE_TIMEOUT;
            resp_rdata    <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        WAIT: begin
          if (mem_rsp_valid) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            if (mem_rsp_err) begin
              resp_err   <= 1'b1;
              resp_cause <= CAUSE_BUS;
              resp_rdata <= '0;
            end else begin
              resp_err   <= 1'b0;
              resp_cause <= CAUSE_MISALIGN;
              resp_rdata <= cap_we ? 32'h0 : load_data;
            end
          end else if (timeout_hit) begin
            state      <= RESP;
            drain      <= 1'b1;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_cause <= CAUSE_TIMEOUT;
            resp_rdata <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: directed requests push expected responses, a monitor checks them.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [1:0]  resp_cause;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_we;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_rsp_valid;
  logic        mem_rsp_ready;
  logic [31:0] mem_rsp_rdata;
  logic        mem_rsp_err;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic [1:0]  cause;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  lsu_ctrl #(.TIMEOUT_CYC(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_funct3    (req_funct3),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_rdata    (resp_rdata),
    .resp_err      (resp_err),
    .resp_cause    (resp_cause),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_we    (mem_req_we),
    .mem_req_addr  (mem_req_addr),
    .mem_req_wdata (mem_req_wdata),
    .mem_req_wstrb (mem_req_wstrb),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_ready (mem_rsp_ready),
    .mem_rsp_rdata (mem_rsp_rdata),
    .mem_rsp_err   (mem_rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: a response is consumed when resp_valid and resp_ready meet at the next edge.
  always @(negedge clk) begin
    if (!rst && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_resp: got rdata 0x%08h err %0d cause %0d with nothing expected",
                 resp_rdata, resp_err, resp_cause);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_err", {31'h0, resp_err}, {31'h0, e.err});
        chk("resp_cause", {30'h0, resp_cause}, {30'h0, e.cause});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the caller one cycle after the request handshake (cycle 1).
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd);
    int n = 0;
    while (!req_ready && n < 50) begin
      tick();
      n++;
    end
    if (!req_ready) begin
      tests++;
      fails++;
      $display("FAIL req_ready_wait: got 0 expected 1 within 50 cycles");
    end
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    tick();
    req_valid = 1'b0;
  endtask

  // Zero-wait-state memory: accept in cycle 1, respond in cycle 2, expect resp_valid in cycle 3.
  task automatic zero_wait(input logic [31:0] rdata, input logic err);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    chk("mem_req_valid_dropped", {31'h0, mem_req_valid}, 32'h0);
    chk("mem_rsp_ready_wait", {31'h0, mem_rsp_ready}, 32'h1);
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = rdata;
    mem_rsp_err   = err;
    tick();
    mem_rsp_valid = 1'b0;
    mem_rsp_err   = 1'b0;
    chk("resp_valid_cycle3", {31'h0, resp_valid}, 32'h1);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
    resp_ready = 1'b1;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_rdata = 0; mem_rsp_err = 0;
    repeat (3) tick();

    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_mem_req_valid", {31'h0, mem_req_valid}, 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_mem_req_addr", mem_req_addr, 32'h0);
    chk("rst_mem_req_wstrb", {28'h0, mem_req_wstrb}, 32'h0);
    rst = 1'b0;
    tick();
    chk("rst_req_ready", {31'h0, req_ready}, 32'h1);

    // LB at 0x1003, word 0x80FF_1234
    exp_q.push_back('{32'hFFFF_FF80, 1'b0, 2'd0});
    issue(1'b0, 3'b000, 32'h0000_1003, 32'h0);
    chk("lb_mem_req_valid", {31'h0, mem_req_valid}, 32'h1);
    chk("lb_mem_req_addr", mem_req_addr, 32'h0000_1000);
    chk("lb_mem_req_wstrb", {28'h0, mem_req_wstrb}, 32'h0);
    chk("lb_mem_req_we", {31'h0, mem_req_we}, 32'h0);
    zero_wait(32'h80FF_1234, 1'b0);
    chk("lb_req_ready_in_resp", {31'h0, req_ready}, 32'h0);
    tick();
    chk("lb_req_ready_after", {31'h0, req_ready}, 32'h1);
    chk("lb_resp_valid_cleared", {31'h0, resp_valid}, 32'h0);

    // LHU at 0x1002 with the consumer stalling for three cycles
    exp_q.push_back('{32'h0000_8001, 1'b0, 2'd0});
    resp_ready = 1'b0;
    issue(1'b0, 3'b101, 32'h0000_1002, 32'h0);
    zero_wait(32'h8001_0000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("lhu_hold_valid", {31'h0, resp_valid}, 32'h1);
      chk("lhu_hold_rdata", resp_rdata, 32'h0000_8001);
    end
    resp_ready = 1'b1;
    tick();

    // LH at 0x1001: misaligned
    exp_q.push_back('{32'h0, 1'b1, 2'd0});
    issue(1'b0, 3'b001, 32'h0000_1001, 32'h0);
    chk("lh_mis_resp_valid_c1", {31'h0, resp_valid}, 32'h1);
    chk("lh_mis_no_mem_req", {31'h0, mem_req_valid}, 32'h0);
    tick();

    // SB at 0x2002, wdata 0xAB
    exp_q.push_back('{32'h0, 1'b0, 2'd0});
    issue(1'b1, 3'b000, 32'h0000_2002, 32'h0000_00AB);
    chk("sb_mem_req_addr", mem_req_addr, 32'h0000_2000);
    chk("sb_mem_req_wdata", mem_req_wdata, 32'hABAB_ABAB);
    chk("sb_mem_req_wstrb", {28'h0, mem_req_wstrb}, 32'h4);
    chk("sb_mem_req_we", {31'h0, mem_req_we}, 32'h1);
    zero_wait(32'h0, 1'b0);
    tick();

    // SW with mem_req_ready low for 5 cycles, then a bus error
    exp_q.push_back('{32'h0, 1'b1, 2'd1});
    issue(1'b1, 3'b010, 32'h0000_3000, 32'hDEAD_BEEF);
    for (int i = 0; i < 5; i++) begin
      chk("sw_stall_valid", {31'h0, mem_req_valid}, 32'h1);
      chk("sw_stall_addr", mem_req_addr, 32'h0000_3000);
      chk("sw_stall_wdata", mem_req_wdata, 32'hDEAD_BEEF);
      chk("sw_stall_wstrb", {28'h0, mem_req_wstrb}, 32'hF);
      tick();
    end
    zero_wait(32'h0, 1'b1);
    tick();

    // Timeout in WAIT, then drain of the late response
    exp_q.push_back('{32'h0, 1'b1, 2'd2});
    issue(1'b0, 3'b010, 32'h0000_4000, 32'h0);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    begin
      int n = 2;
      while (!resp_valid && n < 20) begin
        tick();
        n++;
      end
      chk("timeout_resp_cycle", n, 9);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("drain_req_ready_low", {31'h0, req_ready}, 32'h0);
      chk("drain_mem_rsp_ready", {31'h0, mem_rsp_ready}, 32'h1);
    end
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 32'h1234_5678;
    tick();
    mem_rsp_valid = 1'b0;
    chk("drain_cleared_req_ready", {31'h0, req_ready}, 32'h1);
    exp_q.push_back('{32'hCAFE_F00D, 1'b0, 2'd0});
    issue(1'b0, 3'b010, 32'h0000_5004, 32'h0);
    chk("post_drain_addr", mem_req_addr, 32'h0000_5004);
    zero_wait(32'hCAFE_F00D, 1'b0);
    tick();

    // Illegal load funct3 011
    exp_q.push_back('{32'h0, 1'b1, 2'd3});
    issue(1'b0, 3'b011, 32'h0000_6000, 32'h0);
    chk("illegal_resp_valid_c1", {31'h0, resp_valid}, 32'h1);
    tick();

    // Asynchronous reset while in WAIT
    issue(1'b1, 3'b010, 32'h0000_7000, 32'h5555_AAAA);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    chk("pre_rst_in_wait", {31'h0, mem_rsp_ready}, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("arst_mem_rsp_ready", {31'h0, mem_rsp_ready}, 32'h0);
    chk("arst_mem_req_addr", mem_req_addr, 32'h0);
    chk("arst_mem_req_wdata", mem_req_wdata, 32'h0);
    chk("arst_mem_req_wstrb", {28'h0, mem_req_wstrb}, 32'h0);
    chk("arst_mem_req_we", {31'h0, mem_req_we}, 32'h0);
    chk("arst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("arst_resp_err", {31'h0, resp_err}, 32'h0);
    chk("arst_resp_cause", {30'h0, resp_cause}, 32'h0);
    tick();
    rst = 1'b0;
    tick();
    chk("arst_req_ready", {31'h0, req_ready}, 32'h1);

    repeat (2) tick();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion before 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
